wb_data_ram: RTL and testbench

Wishbone-classic slave data memory that answers the load/store bus requests issued by the OpenMIPS core inside `openmips_min_sopc`. It is the responder end of the core's data-bus interface. It holds a word-addressed RAM, inserts a programmable number of wait states, and honours byte selects. Out-of-range and misaligned accesses are rejected with an error strobe.

---
 rtl/wb_data_ram.sv | 116 +++++++++++
 tb/tb_wb_data_ram.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/wb_data_ram.sv
// wb_data_ram: Wishbone-classic slave data memory with programmable wait
// states, byte-lane writes and an error strobe for misaligned/out-of-range
// addresses.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for cyc & stb; address checked here
// WAIT   | counting down wait states; abort if cyc or stb drops
// ACK    | wb_ack_o high for one cycle; memory accessed on entry
// ERR    | wb_err_o high for one cycle; no memory access
module wb_data_ram #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o
);

  localparam int         DEPTH     = 1 << ADDR_WIDTH;
  localparam bit         WS_ZERO   = (WAIT_STATES == 0);
  localparam logic [3:0] WS_LOAD   = WS_ZERO ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  state_t                  r_state;
  logic [3:0]              r_cnt;
  logic [31:0]             r_dat;
  logic                    r_ack;
  logic                    r_err;
  logic [31:0]             r_mem [0:DEPTH-1];

  logic                    w_req;
  logic                    w_adr_err;
  logic [ADDR_WIDTH-1:0]   w_idx;
  logic                    w_enter_ack;
  logic                    w_mem_we;

  assign w_req     = wb_cyc_i & wb_stb_i;
  assign w_adr_err = (wb_adr_i[1:0] != 2'b00) ||
                     ((wb_adr_i >> (ADDR_WIDTH + 2)) != 32'd0);
  assign w_idx     = wb_adr_i[ADDR_WIDTH+1:2];

  // The access happens on the same edge that moves the FSM into ACK.
  assign w_enter_ack = w_req && !w_adr_err &&
                       (((r_state == ST_IDLE) && WS_ZERO) ||
                        ((r_state == ST_WAIT) && (r_cnt == 4'd0)));
  assign w_mem_we    = w_enter_ack && wb_we_i && !rst;

  assign wb_dat_o = r_dat;
  assign wb_ack_o = r_ack;
  assign wb_err_o = r_err;

  // Byte-lane RAM write; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int n = 0; n < 4; n++) begin
        if (wb_sel_i[n]) r_mem[w_idx][8*n +: 8] <= wb_dat_i[8*n +: 8];
      end
    end
  end

  // Request FSM with wait-state counter and registered bus outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_dat   <= 32'h0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      if (w_enter_ack) begin
        r_state <= ST_ACK;
        r_ack   <= 1'b1;
        if (!wb_we_i) r_dat <= r_mem[w_idx];
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_req) begin
              if (w_adr_err) begin
                r_state <= ST_ERR;
                r_err   <= 1'b1;
              end else begin
                r_state <= ST_WAIT;
                r_cnt   <= WS_LOAD;
              end
            end
          end
          ST_WAIT: begin
            if (!w_req) r_state <= ST_IDLE;
            else        r_cnt   <= r_cnt - 4'd1;
          end
          ST_ACK:  r_state <= ST_IDLE;
          ST_ERR:  r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wb_data_ram.sv
// Self-checking bench for wb_data_ram: one instance with 2 wait states and
// one with zero wait states sharing the bus signals but with separate strobes.
module tb_wb_data_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, we;
  logic        a_stb, b_stb;
  logic [31:0] adr, dat;
  logic [3:0]  sel;
  logic [31:0] a_dat_o, b_dat_o;
  logic        a_ack, a_err, b_ack, b_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          is_err;
    logic [31:0] dat;
    int          lat;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  wb_data_ram #(.ADDR_WIDTH(10), .WAIT_STATES(2)) u_a (
    .clk(clk), .rst(rst), .wb_cyc_i(cyc), .wb_stb_i(a_stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat),
    .wb_dat_o(a_dat_o), .wb_ack_o(a_ack), .wb_err_o(a_err)
  );

  wb_data_ram #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_b (
    .clk(clk), .rst(rst), .wb_cyc_i(cyc), .wb_stb_i(b_stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat),
    .wb_dat_o(b_dat_o), .wb_ack_o(b_ack), .wb_err_o(b_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called between edges; issues one request, waits for ack/err (bounded),
  // then compares against the scoreboard entry pushed at issue time.
  task automatic xfer(input bit use_b, input bit w, input logic [31:0] a,
                      input logic [3:0] s, input logic [31:0] d,
                      input bit exp_err, input logic [31:0] exp_dat, input int exp_lat);
    exp_t e;
    bit   got;
    int   lat;
    logic ack, err;
    e.is_err = exp_err; e.dat = exp_dat; e.lat = exp_lat;
    sb_q.push_back(e);
    cyc = 1'b1; we = w; adr = a; sel = s; dat = d;
    if (use_b) b_stb = 1'b1; else a_stb = 1'b1;
    got = 1'b0; lat = 0; ack = 1'b0; err = 1'b0;
    @(posedge clk);
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clk);
      ack = use_b ? b_ack : a_ack;
      err = use_b ? b_err : a_err;
      if (ack || err) begin
        got = 1'b1;
        lat = i;
      end
    end
    cyc = 1'b0; a_stb = 1'b0; b_stb = 1'b0;
    e = sb_q.pop_front();
    chk("completed", 32'(got), 32'd1);
    chk("latency", lat, e.lat);
    chk("err_flag", 32'(err), 32'(e.is_err));
    chk("ack_flag", 32'(ack), 32'(!e.is_err));
    chk("dat_o", use_b ? b_dat_o : a_dat_o, e.dat);
    @(negedge clk);
    chk("one_cycle", 32'(use_b ? (b_ack | b_err) : (a_ack | a_err)), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n, last;
    rst = 1'b1; cyc = 1'b1; a_stb = 1'b1; b_stb = 1'b0; we = 1'b0;
    adr = 32'h10; sel = 4'hF; dat = 32'h0;

    // Reset held for 3 edges with a request pending
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ack", 32'(a_ack), 32'd0);
      chk("rst_err", 32'(a_err), 32'd0);
      chk("rst_dat", a_dat_o, 32'h0);
    end
    rst = 1'b0;

    // Full write / read, byte lanes
    xfer(0, 1, 32'h10, 4'hF, 32'hDEADBEEF, 0, 32'h0,        3);
    xfer(0, 0, 32'h10, 4'hF, 32'h0,        0, 32'hDEADBEEF, 3);
    xfer(0, 1, 32'h10, 4'h5, 32'h11223344, 0, 32'hDEADBEEF, 3);
    xfer(0, 0, 32'h10, 4'hF, 32'h0,        0, 32'hDE22BE44, 3);

    // Errors: misaligned, out of range, misaligned write into word 4
    xfer(0, 0, 32'h2,    4'hF, 32'h0,        1, 32'hDE22BE44, 1);
    xfer(0, 0, 32'h1000, 4'hF, 32'h0,        1, 32'hDE22BE44, 1);
    xfer(0, 1, 32'h13,   4'hF, 32'hCAFEF00D, 1, 32'hDE22BE44, 1);

    // sel == 0 write leaves memory unchanged
    xfer(0, 1, 32'h14, 4'hF, 32'hAAAA5555, 0, 32'hDE22BE44, 3);
    xfer(0, 1, 32'h14, 4'h0, 32'h12345678, 0, 32'hDE22BE44, 3);
    xfer(0, 0, 32'h14, 4'hF, 32'h0,        0, 32'hAAAA5555, 3);

    // Highest in-range word
    xfer(0, 1, 32'hFFC, 4'hF, 32'h0F0F0F0F, 0, 32'hAAAA5555, 3);
    xfer(0, 0, 32'hFFC, 4'hF, 32'h0,        0, 32'h0F0F0F0F, 3);

    // Abort a write after one wait cycle
    cyc = 1'b1; we = 1'b1; adr = 32'h10; sel = 4'hF; dat = 32'hFFFFFFFF; a_stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_wait_ack", 32'(a_ack), 32'd0);
    @(posedge clk);
    @(negedge clk);
    a_stb = 1'b0; cyc = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_ack", 32'({a_ack, a_err}), 32'd0);
    end
    xfer(0, 0, 32'h10, 4'hF, 32'h0, 0, 32'hDE22BE44, 3);

    // Reset during a write's wait phase: not committed, outputs cleared
    cyc = 1'b1; we = 1'b1; adr = 32'h14; sel = 4'hF; dat = 32'h0; a_stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_ack", 32'(a_ack), 32'd0);
    chk("midrst_dat", a_dat_o, 32'h0);
    rst = 1'b0; a_stb = 1'b0; cyc = 1'b0;
    @(negedge clk);
    chk("midrst_idle", 32'({a_ack, a_err}), 32'd0);
    xfer(0, 0, 32'h14, 4'hF, 32'h0, 0, 32'hAAAA5555, 3);

    // Zero wait states: preload then 4 back-to-back reads with stb held
    for (int i = 0; i < 4; i++)
      xfer(1, 1, 32'(i * 4), 4'hF, 32'hC0DE0000 + 32'(i), 0, 32'h0, 1);
    for (int i = 0; i < 4; i++) begin
      e.is_err = 1'b0; e.dat = 32'hC0DE0000 + 32'(i); e.lat = 2;
      sb_q.push_back(e);
    end
    cyc = 1'b1; we = 1'b0; adr = 32'h0; sel = 4'hF; b_stb = 1'b1;
    n = 0; last = 0;
    for (int c = 1; c <= 40 && n < 4; c++) begin
      @(negedge clk);
      chk("b2b_err", 32'(b_err), 32'd0);
      if (b_ack) begin
        e = sb_q.pop_front();
        chk("b2b_dat", b_dat_o, e.dat);
        if (n == 0) chk("b2b_first_lat", c, 1);
        else        chk("b2b_period", c - last, e.lat);
        last = c;
        n++;
        adr = 32'(n * 4);
        if (n == 4) begin
          b_stb = 1'b0; cyc = 1'b0;
        end
      end
    end
    chk("b2b_count", n, 4);
    @(negedge clk);
    chk("b2b_done", 32'(b_ack), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
